// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } ctrl_state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: a load in EX feeds a source read by the ID instruction.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1_addr,
  input  logic [4:0] id_rs2_addr,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] ex_rd_addr,
  input  logic       ex_writeback_en,
  input  logic       ex_writeback_from_mem,
  output logic       load_use
);

  logic ex_is_load;
  logic rs1_match;
  logic rs2_match;

  // x0 is never a real destination, so reset-state bubbles cannot stall.
  assign ex_is_load = ex_writeback_en && ex_writeback_from_mem && (ex_rd_addr != REG_X0);
  assign rs1_match  = id_uses_rs1 && (id_rs1_addr == ex_rd_addr);
  assign rs2_match  = id_uses_rs2 && (id_rs2_addr == ex_rd_addr);
  assign load_use   = ex_is_load && (rs1_match || rs2_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: memory-wait freeze with watchdog, branch squash, load-use bubble.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_writeback_en,
  input  logic             ex_writeback_from_mem,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             skip_pc,
  output logic             skip_if_id,
  output logic             skip_id_ex,
  output logic             skip_ex_m,
  output logic             skip_m_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             bus_error,
  output logic [CNT_W-1:0] stall_count
);

  localparam int                WAIT_W      = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX    = '1;
  localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;

  ctrl_state_t       state_reg, state_next;
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic              bus_error_reg;
  logic [CNT_W-1:0]  stall_count_reg;

  logic load_use;
  logic freeze;
  logic normal;
  logic any_skip;

  load_use_detect u_load_use_detect (
    .id_rs1_addr           (id_rs1_addr),
    .id_rs2_addr           (id_rs2_addr),
    .id_uses_rs1           (id_uses_rs1),
    .id_uses_rs2           (id_uses_rs2),
    .ex_rd_addr            (ex_rd_addr),
    .ex_writeback_en       (ex_writeback_en),
    .ex_writeback_from_mem (ex_writeback_from_mem),
    .load_use              (load_use)
  );

  // Next-state and watchdog counter.
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    freeze        = 1'b0;
    normal        = 1'b0;
    case (state_reg)
      RUN: begin
        if (mem_req && !mem_ready) begin
          freeze        = 1'b1;
          state_next    = MEM_WAIT;
          wait_cnt_next = WAIT_W'(1);
        end else begin
          normal = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!mem_ready) begin
          freeze = 1'b1;
          if (wait_cnt_reg != WAIT_MAX) begin
            wait_cnt_next = wait_cnt_reg + 1'b1;
          end
          if ((MEM_TIMEOUT != 0) && (wait_cnt_reg == TIMEOUT_VAL)) begin
            state_next = FAULT;
          end
        end else begin
          // Release happens in the ready cycle itself, so normal hazard rules apply now.
          normal        = 1'b1;
          state_next    = RUN;
          wait_cnt_next = '0;
        end
      end
      FAULT: begin
        freeze = 1'b1;
      end
      default: begin
        state_next    = RUN;
        wait_cnt_next = '0;
      end
    endcase
  end

  // Priority mux: freeze over branch squash over load-use bubble.
  always_comb begin
    skip_pc     = 1'b0;
    skip_if_id  = 1'b0;
    skip_id_ex  = 1'b0;
    skip_ex_m   = 1'b0;
    skip_m_wb   = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    if (!rst) begin
      if (freeze) begin
        skip_pc    = 1'b1;
        skip_if_id = 1'b1;
        skip_id_ex = 1'b1;
        skip_ex_m  = 1'b1;
        skip_m_wb  = 1'b1;
      end else if (normal && ex_branch_taken) begin
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end else if (normal && load_use) begin
        skip_pc     = 1'b1;
        skip_if_id  = 1'b1;
        flush_id_ex = 1'b1;
      end
    end
  end

  assign any_skip = skip_pc | skip_if_id | skip_id_ex | skip_ex_m | skip_m_wb;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= RUN;
      wait_cnt_reg    <= '0;
      bus_error_reg   <= 1'b0;
      stall_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      wait_cnt_reg  <= wait_cnt_next;
      bus_error_reg <= (state_next == FAULT);
      if (any_skip && (stall_count_reg != CNT_MAX)) begin
        stall_count_reg <= stall_count_reg + 1'b1;
      end
    end
  end

  assign bus_error   = bus_error_reg;
  assign stall_count = stall_count_reg;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the 5-stage pipelined RISC-V core. It drives the `skip` (hold) and flush (bubble) inputs of every inter-stage register (IF/ID, ID/EX, EX/M, M/WB) and the PC. It resolves three conditions:
- load-use hazards;
- taken-branch squash;
- multi-cycle data-memory waits, with a watchdog that faults on a hung bus.

## Interface

Parameters:
- `MEM_TIMEOUT`, default 64: maximum consecutive wait cycles before fault; 0 disables the watchdog.
- `CNT_W`, default 32: width of the stall performance counter.

Ports (name, direction, width, meaning):
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `id_rs1_addr`, `id_rs2_addr` input 5: source registers of the instruction in ID.
- `id_uses_rs1`, `id_uses_rs2` input 1: the ID instruction actually reads that source.
- `ex_rd_addr` input 5: destination register of the instruction in EX.
- `ex_writeback_en` input 1: the EX instruction writes `rd`.
- `ex_writeback_from_mem` input 1: the EX instruction is a load.
- `ex_branch_taken` input 1: the EX instruction redirects the PC.
- `mem_req` input 1: the M stage holds a memory access.
- `mem_ready` input 1: data memory completes the access this cycle.
- `skip_pc`, `skip_if_id`, `skip_id_ex`, `skip_ex_m`, `skip_m_wb` output 1: hold the corresponding register.
- `flush_if_id`, `flush_id_ex` output 1: load a bubble (`writeback_en=0`, `rd_addr=0`) into that register.
- `bus_error` output 1: sticky watchdog fault.
- `stall_count` output `CNT_W`: number of cycles with any `skip_*` asserted; saturates at all-ones.

## Operation

Load-use detection:
- `load_use` is asserted when all of the following hold: `ex_writeback_en`, `ex_writeback_from_mem`, `ex_rd_addr != 0`.
- It additionally requires a source match: `(id_uses_rs1 && id_rs1_addr == ex_rd_addr)` or `(id_uses_rs2 && id_rs2_addr == ex_rd_addr)`.
- `rd_addr == 0` never creates a hazard, so reset-state register contents (`rd=0`, `writeback_en=1`) are harmless.

FSM states:
- RUN:
  - If `mem_req && !mem_ready`: freeze, meaning all five `skip_*` are 1 and both flushes are 0. Next state is MEM_WAIT with `wait_cnt=1`.
  - Else, if `ex_branch_taken`: `flush_if_id=1`, `flush_id_ex=1`, all skips 0.
  - Else, if `load_use`: `skip_pc=1`, `skip_if_id=1`, `flush_id_ex=1`, all other outputs 0.
  - Else: all outputs 0.
- MEM_WAIT:
  - If `!mem_ready`: freeze, and `wait_cnt` increments.
  - If `!mem_ready` and `MEM_TIMEOUT != 0` and `wait_cnt == MEM_TIMEOUT`: next state is FAULT.
  - If `mem_ready`: the freeze is released in that same cycle, and the branch and load-use rules above apply to that cycle. Next state is RUN and `wait_cnt` clears to 0.
- FAULT: all `skip_*` are 1 and `bus_error` is 1. The block stays in FAULT until `rst`; no input can leave this state.

Priority, highest first: FAULT, memory freeze, branch flush, load-use. A branch beats load-use because the dependent ID instruction is being squashed anyway.

`wait_cnt` width is `$clog2(MEM_TIMEOUT+1)`, with a minimum of 1 bit; it never wraps.

## Timing

- All outputs except `bus_error` and `stall_count` are combinational from the registered state and the current inputs, with no added latency.
- `bus_error` and `stall_count` are registered.
- While `rst=1`, every `skip_*` and `flush_*` is 0, because the pipeline registers self-reset.
- On the reset edge: state becomes RUN, `wait_cnt=0`, `bus_error=0`, `stall_count=0`.
- Reset asserted in MEM_WAIT or FAULT returns the block to RUN on the next edge; no pending wait survives reset.
- Load-use costs exactly 1 bubble. On the next cycle the load has moved to M, so `load_use` deasserts without any stored state.
- A memory wait of N cycles, where `mem_ready` arrives on the (N+1)th cycle, produces N frozen cycles.
- The timeout fires when `mem_ready` is still low after `MEM_TIMEOUT` frozen cycles. `bus_error` rises on the following edge.
- `stall_count` increments on every edge whose preceding cycle had any `skip_*=1`; this includes FAULT cycles and load-use cycles.

## Structure

- Package `pipe_ctrl_pkg` holds:
  - `typedef enum logic [1:0] {RUN, MEM_WAIT, FAULT} ctrl_state_t`;
  - the constant `REG_X0 = 5'd0`.
- Sub-module `load_use_detect`, purely combinational, computes `load_use`. The top level holds the FSM, the watchdog, the counter and the priority mux.

## Test plan

- Load-use: `ex_rd_addr=5`, load, `id_rs1_addr=5`, `id_uses_rs1=1` -> for one cycle, `skip_pc=skip_if_id=flush_id_ex=1`; next cycle (rd moved on) all 0; `stall_count=1`.
- Load-use on x0, or with `id_uses_rs2=0` and only rs2 matching -> no stall, no flush.
- Branch and load-use together: `ex_branch_taken=1` with load-use conditions true -> `flush_if_id=flush_id_ex=1`, `skip_pc=0`.
- Memory wait: `mem_req=1` with `mem_ready` low for 3 cycles, then high -> 3 frozen cycles; release in the 4th cycle; state back to RUN; `stall_count=3`.
- Watchdog: `MEM_TIMEOUT=4`, `mem_ready` held low -> 5 frozen cycles, state FAULT, `bus_error=1` after the next edge, outputs frozen until `rst`. Then pulse `rst`: `bus_error=0`, RUN, `stall_count=0`.
- Reset mid-wait: `rst=1` during MEM_WAIT -> outputs 0 during reset; RUN afterward; `wait_cnt` cleared, so a fresh wait counts from 1.
